// File: rtl/restore_cell_multiplier_pkg.sv
// Shared types and helpers for the restoring-cell multiplier.
// Optional build macro: RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN (see top).
package restore_cell_pkg;

  // Control states of the multiplier sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Reference reconstruction q*d+r for benches; wide enough for any WIDTH <= 16.
  function automatic logic [63:0] ref_mult(input logic [63:0] q,
                                           input logic [63:0] d,
                                           input logic [63:0] r);
    return q * d + r;
  endfunction

endpackage

// File: rtl/restore_cell_multiplier_if.sv
// Operand/result bus of the restoring-cell multiplier.
// master drives operands and consumes the result; slave is the multiplier.
interface restore_cell_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 din_valid;
  logic                 din_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     remainder;
  logic                 dout_valid;
  logic [3*WIDTH-1:0]   dout;

  modport master (
    output din_valid, quotient, divisor, remainder,
    input  din_ready, dout_valid, dout
  );

  modport slave (
    input  din_valid, quotient, divisor, remainder,
    output din_ready, dout_valid, dout
  );
endinterface

// File: rtl/restore_cell_multiplier_step.sv
// One shift-add step: conditionally add the multiplicand into the
// accumulator on the current multiplier LSB, then advance both operands.
// Purely combinational; the top reuses a single instance every CALC cycle.
module mult_step_cell #(
  parameter int WIDTH = 4,
  localparam int RW = 3 * WIDTH
) (
  input  logic [RW-1:0]    acc,
  input  logic [RW-1:0]    mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [RW-1:0]    acc_nxt,
  output logic [RW-1:0]    mcand_nxt,
  output logic [WIDTH-1:0] mplier_nxt
);

  // Modulo-RW add is safe: the full product plus addend always fits in RW.
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/restore_cell_multiplier.sv
// Sequential shift-add multiplier: dout = quotient*divisor + remainder.
// One divisor bit per CALC cycle, valid/ready input, one-cycle done pulse.
// Build macro RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN: leave CALC as soon as
// the remaining multiplier bits are all zero (same results, shorter latency).
module restore_cell_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  restore_cell_multiplier_if.slave bus
);
  import restore_cell_pkg::*;

  localparam int QW = 2 * WIDTH;
  localparam int RW = 3 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_e      state, state_nxt;
  logic [RW-1:0]    acc, mcand, dout_r;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [RW-1:0]    acc_nxt, mcand_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             accept, last_step;

  assign bus.din_ready  = (state == IDLE) || (state == DONE);
  assign bus.dout_valid = (state == DONE);
  assign bus.dout       = dout_r;
  assign accept         = bus.din_valid && bus.din_ready;

  mult_step_cell #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

`ifdef RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN
  // Once no multiplier bits remain, further steps cannot change acc.
  assign last_step = (cnt == CW'(WIDTH - 1)) || (mplier_nxt == '0);
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE can chain straight into a new operation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, step in CALC, latch result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      dout_r <= '0;
    end else if (accept) begin
      acc    <= RW'(bus.remainder);
      mcand  <= RW'(bus.quotient);
      mplier <= bus.divisor;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt + 1'b1;
      if (last_step) dout_r <= acc_nxt;
    end
  end

  // QW documents the multiplicand width carried on the bus.
  logic [QW-1:0] unused_q;
  assign unused_q = bus.quotient;

endmodule

// File: tb/tb_restore_cell_multiplier.sv
// Bench for restore_cell_multiplier (WIDTH=4): per-cycle comparison against a
// transaction-level model plus directed literal expectations.
module tb_restore_cell_multiplier;
  import restore_cell_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  restore_cell_multiplier_if #(.WIDTH(W)) bus ();

  restore_cell_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Number of CALC cycles an operation with divisor d occupies.
  function automatic int exp_lat(input logic [31:0] d);
`ifdef RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (d[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Transaction model: busy countdown, pending result, visible result.
  int              m_rem = 0;
  logic [3*W-1:0]  m_pending = '0;
  logic [3*W-1:0]  m_dout = '0;
  logic            m_valid = 1'b0;
  bit              started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem   = 0;
      m_valid = 1'b0;
      m_dout  = '0;
      started = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_dout  = m_pending;
          m_valid = 1'b1;
        end
      end else if (bus.din_valid) begin
        m_pending = 12'(int'(bus.quotient) * int'(bus.divisor) + int'(bus.remainder));
        m_rem     = exp_lat(32'(bus.divisor));
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      check("cyc_dout_valid", 64'(bus.dout_valid), 64'(m_valid));
      check("cyc_din_ready", 64'(bus.din_ready), 64'(m_rem == 0));
      check("cyc_dout", 64'(bus.dout), 64'(m_dout));
    end
  end

  task automatic drive(input int q, input int d, input int r, input logic v);
    bus.quotient  = 8'(q);
    bus.divisor   = 4'(d);
    bus.remainder = 4'(r);
    bus.din_valid = v;
  endtask

  // Wait (bounded) for the done pulse; lat counts edges since the caller's point.
  task automatic wait_done(output logic [11:0] res, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.dout_valid && lat < 50);
    if (!bus.dout_valid) begin
      failures++;
      $display("FAIL wait_done timeout actual=no_pulse expected=pulse");
    end
    res = bus.dout;
  endtask

  task automatic send_op(input int q, input int d, input int r,
                         output logic [11:0] res, output int lat);
    int n = 0;
    while (!bus.din_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.din_ready) begin
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    drive(q, d, r, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    wait_done(res, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] res;
    int lat, seen, dv, ds;

    drive(0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    check("rst_dout", 64'(bus.dout), 0);
    check("rst_dout_valid", 64'(bus.dout_valid), 0);
    check("rst_din_ready", 64'(bus.din_ready), 1);
    check("ref_mult_lit", ref_mult(200, 7, 3), 1403);

    // Basic: pulse visible after WIDTH CALC edges (fixed build).
    send_op(200, 7, 3, res, lat);
    check("basic_dout", 64'(res), 1403);
`ifdef RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN
    check("basic_lat", 64'(lat), 3);
`else
    check("basic_lat", 64'(lat), 4);
`endif

    // Max operands, no truncation.
    send_op(255, 15, 15, res, lat);
    check("max_dout", 64'(res), 12'hF00);
    check("max_lat", 64'(lat), 4);

    // Zero divisor.
    send_op(77, 0, 9, res, lat);
    check("zero_div_dout", 64'(res), 9);
`ifdef RESTORE_CELL_MULTIPLIER_EARLY_TERM_EN
    check("zero_div_lat", 64'(lat), 1);
`else
    check("zero_div_lat", 64'(lat), 4);
`endif

    // Zero quotient.
    send_op(0, 13, 6, res, lat);
    check("zero_q_dout", 64'(res), 6);

    // Back-to-back with a din_valid pulse during CALC that must be ignored.
    drive(10, 3, 2, 1'b1);
    @(posedge clk); #1;
    drive(1, 1, 1, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    wait_done(res, lat);
    check("b2b_first", 64'(res), 32);
    drive(5, 5, 4, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    check("b2b_busy", 64'(bus.din_ready), 0);
    wait_done(res, lat);
    check("b2b_second", 64'(res), 29);
    @(posedge clk); #1;
    check("b2b_no_extra", 64'(bus.dout_valid), 0);

    // Reset in the 2nd CALC cycle aborts the operation.
    drive(100, 9, 1, 1'b1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_dout", 64'(bus.dout), 0);
    check("abort_dout_valid", 64'(bus.dout_valid), 0);
    check("abort_din_ready", 64'(bus.din_ready), 1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.dout_valid) seen++;
    end
    check("abort_no_pulse", 64'(seen), 0);
    send_op(3, 3, 0, res, lat);
    check("after_abort", 64'(res), 9);

    // Round-trip against an integer division of a random dividend.
    for (int i = 0; i < 1000; i++) begin
      dv = $urandom_range(255);
      ds = $urandom_range(15, 1);
      send_op(dv / ds, ds, dv % ds, res, lat);
      check("round_trip", 64'(res), 64'(dv));
    end

    // Unconstrained random stream; the per-cycle compare does the checking.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(255), $urandom_range(15), $urandom_range(15),
            1'($urandom_range(1)));
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
